// File: rtl/icache_pkg.sv
// Shared types and field widths for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned OFFSET_W          = 4;
  localparam int unsigned WORD_SEL_W        = 2;
  localparam int unsigned BLOCK_ADDR_W      = ADDR_W - OFFSET_W;
  localparam int unsigned DEFAULT_NUM_LINES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StUpdate
  } state_e;

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage: combinational read port, synchronous write port.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEFAULT_NUM_LINES,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned INDEX_W   = 3,
  parameter int unsigned TAG_W     = 25
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INDEX_W-1:0]   rd_index_i,
  output logic                 rd_valid_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [LINE_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [INDEX_W-1:0]   wr_index_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Only the valid bits are reset; tag and data contents are don't-care until filled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a three-state block fill FSM.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEFAULT_NUM_LINES,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_read,
  input  logic [ADDR_W-1:0]       cpu_address,
  output logic [31:0]             cpu_instruction,
  output logic                    cpu_busywait,
  output logic                    mem_read,
  output logic [BLOCK_ADDR_W-1:0] mem_address,
  input  logic [LINE_BITS-1:0]    mem_readdata,
  input  logic                    mem_busywait
);

  localparam int unsigned IndexW = $clog2(NUM_LINES);
  localparam int unsigned TagW   = ADDR_W - OFFSET_W - IndexW;

  state_e                  state_q;
  logic [BLOCK_ADDR_W-1:0] fill_addr_q;
  logic                    mem_read_q;

  logic [WORD_SEL_W-1:0] word_sel;
  logic [IndexW-1:0]     rd_index;
  logic [TagW-1:0]       req_tag;
  logic                  line_valid;
  logic [TagW-1:0]       line_tag;
  logic [LINE_BITS-1:0]  line_data;
  logic                  hit;
  logic                  unused_addr_bits;

  assign word_sel         = cpu_address[OFFSET_W-1 -: WORD_SEL_W];
  assign rd_index         = cpu_address[OFFSET_W +: IndexW];
  assign req_tag          = cpu_address[ADDR_W-1 -: TagW];
  assign unused_addr_bits = ^cpu_address[OFFSET_W-WORD_SEL_W-1:0];

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .INDEX_W   (IndexW),
    .TAG_W     (TagW)
  ) u_line_array (
    .clock      (clock),
    .reset      (reset),
    .rd_index_i (rd_index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (state_q == StUpdate),
    .wr_index_i (fill_addr_q[IndexW-1:0]),
    .wr_tag_i   (fill_addr_q[BLOCK_ADDR_W-1 -: TagW]),
    .wr_data_i  (mem_readdata)
  );

  // Hits are only honoured in idle so a line is never read while it is being refilled.
  assign hit = (state_q == StIdle) && line_valid && (line_tag == req_tag);

  always_comb begin
    cpu_instruction = '0;
    if (hit) begin
      cpu_instruction = line_data[{word_sel, 5'b0} +: 32];
    end
  end

  assign cpu_busywait = cpu_read && !hit;
  assign mem_read     = mem_read_q;
  assign mem_address  = fill_addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fill_addr_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_read && !hit) begin
            state_q     <= StMemRead;
            fill_addr_q <= cpu_address[ADDR_W-1:OFFSET_W];
            mem_read_q  <= 1'b1;
          end
        end
        StMemRead: begin
          if (!mem_busywait) begin
            state_q    <= StUpdate;
            mem_read_q <= 1'b0;
          end
        end
        StUpdate: begin
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomised bench for icache against a line-level cache model and a 16-cycle block memory.
module tb_icache;

  localparam int unsigned NL = 8;
  localparam int unsigned IW = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_read = 1'b0;
  logic [31:0]  cpu_address = 32'h0;
  logic [31:0]  cpu_instruction;
  logic         cpu_busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int errors = 0;
  int checks = 0;
  int mem_cycles = 0;

  icache u_dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_read        (cpu_read),
    .cpu_address     (cpu_address),
    .cpu_instruction (cpu_instruction),
    .cpu_busywait    (cpu_busywait),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .mem_readdata    (mem_readdata),
    .mem_busywait    (mem_busywait)
  );

  always #5 clock = ~clock;

  // Instruction memory: a 4 KiB table, aliased above 4 KiB with the upper address bits mixed in.
  logic [31:0] rom [1024];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return rom[a[11:2]] ^ (a & 32'hFFFF_F000);
  endfunction

  function automatic logic [127:0] block_at(input logic [27:0] ba);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = word_at({ba, 4'b0} + 32'(w * 4));
    return b;
  endfunction

  assign mem_readdata = block_at(mem_address);

  logic [3:0] mcnt;
  assign mem_busywait = mem_read && (mcnt != 4'd15);

  always @(posedge clock or posedge reset) begin
    if (reset) mcnt <= 4'd0;
    else if (mem_read) mcnt <= mcnt + 4'd1;
  end

  // Cache model: per-line valid/tag, plus a countdown of the busy cycles left in a fill.
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  int          fill_cnt = 0;
  logic [31:0] fill_addr = 32'h0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % NL);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (4 + IW);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (fill_cnt == 0) && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NL); i++) m_valid[i] <= 1'b0;
      fill_cnt  <= 0;
      fill_addr <= 32'h0;
    end else if (fill_cnt != 0) begin
      if (fill_cnt == 1) begin
        m_valid[idx_of(fill_addr)] <= 1'b1;
        m_tag[idx_of(fill_addr)]   <= tag_of(fill_addr);
      end
      fill_cnt <= fill_cnt - 1;
    end else if (cpu_read && !m_hit(cpu_address)) begin
      // 16 transfer cycles followed by one update cycle.
      fill_cnt  <= 17;
      fill_addr <= cpu_address;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit          e_hit;
    logic [31:0] e_instr;
    e_hit   = m_hit(cpu_address);
    e_instr = e_hit ? word_at(cpu_address) : 32'h0;
    check("busywait", 32'(cpu_busywait), 32'(cpu_read && !e_hit));
    check("instruction", cpu_instruction, e_instr);
    check("mem_read", 32'(mem_read), 32'(fill_cnt >= 2));
    check("mem_address", 32'(mem_address), 32'(fill_addr[31:4]));
    if (fill_cnt == 1) check("mem_counter_idle", 32'(mcnt), 32'h0);
    if (mem_read) mem_cycles++;
  end

  task automatic read_wait(input logic [31:0] a, output int stalls, output logic [31:0] instr);
    cpu_read    = 1'b1;
    cpu_address = a;
    stalls      = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!cpu_busywait) break;
      stalls++;
      @(posedge clock);
      #1;
    end
    instr = cpu_instruction;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] upper;
    case ($urandom % 3)
      0:       upper = 32'h0000_0000;
      1:       upper = 32'h8000_0000;
      default: upper = 32'h0001_2000;
    endcase
    return upper | ($urandom & 32'h0000_03FF);
  endfunction

  initial begin
    int          st;
    logic [31:0] ins;
    int          mc;
    int          cnt;

    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'hC180_0013;
    rom[1] = 32'h0020_8093;
    rom[7] = 32'h0050_A103;

    #1 reset = 1'b1;
    cpu_read = 1'b1;
    @(negedge clock);
    check("reset_busywait", 32'(cpu_busywait), 32'h1);
    check("reset_instr", cpu_instruction, 32'h0);
    check("reset_mem_read", 32'(mem_read), 32'h0);
    check("reset_mem_address", 32'(mem_address), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    cpu_read = 1'b0;
    @(posedge clock);
    #1;

    mc = mem_cycles;
    read_wait(32'h0, st, ins);
    check("cold_miss_stalls", 32'(st), 32'd18);
    check("cold_miss_data", ins, 32'hC180_0013);
    check("cold_miss_mem_cycles", 32'(mem_cycles - mc), 32'd16);

    mc = mem_cycles;
    read_wait(32'h4, st, ins);
    check("hit_stalls", 32'(st), 32'd0);
    check("hit_data", ins, 32'h0020_8093);
    check("hit_no_mem_read", 32'(mem_cycles - mc), 32'd0);

    read_wait(32'h1C, st, ins);
    check("block1_stalls", 32'(st), 32'd18);
    check("block1_data", ins, 32'h0050_A103);
    read_wait(32'h0, st, ins);
    check("line0_persists_stalls", 32'(st), 32'd0);
    check("line0_persists_data", ins, 32'hC180_0013);

    read_wait(32'h80, st, ins);
    check("evict_fill_stalls", 32'(st), 32'd18);
    check("evict_fill_data", ins, word_at(32'h80));
    read_wait(32'h0, st, ins);
    check("evicted_refill_stalls", 32'(st), 32'd18);
    check("evicted_refill_data", ins, 32'hC180_0013);

    cpu_read    = 1'b1;
    cpu_address = 32'h40;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 8; i++) begin
      @(negedge clock);
      if (mem_read) cnt++;
    end
    check("mid_fill_reached", 32'(cnt), 32'd8);
    #1 reset = 1'b1;
    #1;
    check("mid_fill_reset_mem_read", 32'(mem_read), 32'h0);
    check("mid_fill_reset_busywait", 32'(cpu_busywait), 32'h1);
    check("mid_fill_reset_instr", cpu_instruction, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    read_wait(32'h0, st, ins);
    check("post_reset_stalls", 32'(st), 32'd18);
    check("post_reset_data", ins, 32'hC180_0013);

    mc = mem_cycles;
    cpu_read    = 1'b1;
    cpu_address = 32'h200;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    cpu_read    = 1'b0;
    cpu_address = 32'h300;
    repeat (20) begin
      @(posedge clock);
      #1;
    end
    check("dropped_fill_mem_cycles", 32'(mem_cycles - mc), 32'd16);
    mc = mem_cycles;
    read_wait(32'h200, st, ins);
    check("dropped_fill_hit_stalls", 32'(st), 32'd0);
    check("dropped_fill_hit_data", ins, word_at(32'h200));
    check("dropped_fill_no_mem_read", 32'(mem_cycles - mc), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      if (reset) reset = 1'b0;
      else if (($urandom % 1000) < 3) reset = 1'b1;
      cpu_read = ($urandom % 4) != 0;
      if (($urandom % 3) == 0) cpu_address = rand_addr();
      @(posedge clock);
      #1;
    end

    reset    = 1'b0;
    cpu_read = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
